// File: rtl/mod_exp_ctrl_if.sv
// Host-side request/result signals and the Montgomery product handshake for mod_exp_ctrl.
// The master side is the sequencer; the slave side is the RSA top level plus the product unit.
interface mod_exp_ctrl_if #(
   parameter int unsigned bitLen = 64,
   parameter int unsigned expLen = 64
);
   logic              start;
   logic [bitLen-1:0] base_m;
   logic [bitLen-1:0] one_m;
   logic [expLen-1:0] exp;
   logic [bitLen-1:0] M;
   logic              busy;
   logic              done;
   logic [bitLen-1:0] result;
   logic              mp_start;
   logic [bitLen-1:0] mp_A;
   logic [bitLen-1:0] mp_B;
   logic [bitLen-1:0] mp_M;
   logic              mp_done;
   logic [bitLen-1:0] mp_P;

   modport master (
      input  start, base_m, one_m, exp, M, mp_done, mp_P,
      output busy, done, result, mp_start, mp_A, mp_B, mp_M
   );

   modport slave (
      output start, base_m, one_m, exp, M, mp_done, mp_P,
      input  busy, done, result, mp_start, mp_A, mp_B, mp_M
   );
endinterface

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving one shared Montgomery product unit,
// finishing with a product by 1 to leave the Montgomery domain.
module mod_exp_ctrl #(
   parameter int unsigned bitLen = 64,
   parameter int unsigned expLen = 64,
   parameter int unsigned bits_e = 7
) (
   input  logic           clk,
   input  logic           rst,
   mod_exp_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      StIdle, StSqr, StSqrWait, StMul, StMulWait, StConv, StConvWait, StFin
   } state_e;

   localparam logic [bits_e-1:0] IdxTop = bits_e'(expLen - 1);

   state_e            r_state, w_state_nxt;
   logic [bitLen-1:0] r_acc, w_acc_nxt;
   logic [bitLen-1:0] r_base, w_base_nxt;
   logic [bitLen-1:0] r_m, w_m_nxt;
   logic [bitLen-1:0] r_result, w_result_nxt;
   logic [expLen-1:0] r_exp, w_exp_nxt;
   logic [bits_e-1:0] r_index, w_index_nxt;
   logic [expLen-1:0] w_exp_sh;
   logic              w_bit;
   logic              w_last;

   assign w_exp_sh = r_exp >> r_index;
   assign w_bit    = w_exp_sh[0];
   assign w_last   = (r_index == '0);

   assign bus.busy   = (r_state != StIdle);
   assign bus.done   = (r_state == StFin);
   assign bus.result = r_result;
   assign bus.mp_M   = r_m;

   always_comb begin
      w_state_nxt  = r_state;
      w_acc_nxt    = r_acc;
      w_base_nxt   = r_base;
      w_m_nxt      = r_m;
      w_result_nxt = r_result;
      w_exp_nxt    = r_exp;
      w_index_nxt  = r_index;
      bus.mp_start = 1'b0;
      bus.mp_A     = '0;
      bus.mp_B     = '0;
      case (r_state)
         StIdle: begin
            if (bus.start) begin
               w_base_nxt  = bus.base_m;
               w_exp_nxt   = bus.exp;
               w_m_nxt     = bus.M;
               w_acc_nxt   = bus.one_m;
               w_index_nxt = IdxTop;
               w_state_nxt = StSqr;
            end
         end
         StSqr: begin
            bus.mp_start = 1'b1;
            bus.mp_A     = r_acc;
            bus.mp_B     = r_acc;
            w_state_nxt  = StSqrWait;
         end
         // acc only changes on mp_done, so operands stay stable for the whole wait
         StSqrWait: begin
            bus.mp_A = r_acc;
            bus.mp_B = r_acc;
            if (bus.mp_done) begin
               w_acc_nxt = bus.mp_P;
               if (w_bit) begin
                  w_state_nxt = StMul;
               end else if (w_last) begin
                  w_state_nxt = StConv;
               end else begin
                  w_index_nxt = r_index - bits_e'(1);
                  w_state_nxt = StSqr;
               end
            end
         end
         StMul: begin
            bus.mp_start = 1'b1;
            bus.mp_A     = r_acc;
            bus.mp_B     = r_base;
            w_state_nxt  = StMulWait;
         end
         StMulWait: begin
            bus.mp_A = r_acc;
            bus.mp_B = r_base;
            if (bus.mp_done) begin
               w_acc_nxt = bus.mp_P;
               if (w_last) begin
                  w_state_nxt = StConv;
               end else begin
                  w_index_nxt = r_index - bits_e'(1);
                  w_state_nxt = StSqr;
               end
            end
         end
         StConv: begin
            bus.mp_start = 1'b1;
            bus.mp_A     = r_acc;
            bus.mp_B     = bitLen'(1);
            w_state_nxt  = StConvWait;
         end
         StConvWait: begin
            bus.mp_A = r_acc;
            bus.mp_B = bitLen'(1);
            if (bus.mp_done) begin
               w_result_nxt = bus.mp_P;
               w_state_nxt  = StFin;
            end
         end
         StFin: begin
            w_state_nxt = StIdle;
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= StIdle;
         r_acc    <= '0;
         r_base   <= '0;
         r_m      <= '0;
         r_result <= '0;
         r_exp    <= '0;
         r_index  <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_acc    <= w_acc_nxt;
         r_base   <= w_base_nxt;
         r_m      <= w_m_nxt;
         r_result <= w_result_nxt;
         r_exp    <= w_exp_nxt;
         r_index  <= w_index_nxt;
      end
   end

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Directed bench for mod_exp_ctrl with a behavioural Montgomery product model (R = 256).
// Golden values use base 2, M = 13: 2 has order 12 mod 13, so 2^e mod 13 = 2^(e mod 12).
module tb_mod_exp_ctrl;

   localparam int unsigned BitLen = 8;
   localparam int unsigned ExpLen = 8;
   localparam int          Limit  = 3000;

   logic clk;
   logic rst;

   mod_exp_ctrl_if #(.bitLen(BitLen), .expLen(ExpLen)) bus ();

   mod_exp_ctrl #(.bitLen(BitLen), .expLen(ExpLen), .bits_e(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;

   // product model state
   logic       model_done = 1'b0;
   logic [7:0] model_p    = '0;
   logic       stray_done = 1'b0;
   logic [7:0] stray_p    = '0;
   logic [7:0] a_l, b_l, m_l;
   int         cnt        = 0;
   int         n_starts   = 0;
   int         stab_err   = 0;
   int         fixed_lat  = 3;
   logic       rand_lat   = 1'b0;

   assign bus.mp_done = model_done | stray_done;
   assign bus.mp_P    = stray_done ? stray_p : model_p;

   function automatic int mont(input int a, input int b, input int m);
      int rinv;
      rinv = 0;
      for (int x = 1; x < m; x++) if (((256 * x) % m) == 1) rinv = x;
      return (a * b * rinv) % m;
   endfunction

   always @(posedge clk) begin
      model_done <= 1'b0;
      if (rst) begin
         cnt <= 0;
      end else if (bus.mp_start) begin
         n_starts <= n_starts + 1;
         if (cnt != 0) stab_err <= stab_err + 1;
         a_l <= bus.mp_A;
         b_l <= bus.mp_B;
         m_l <= bus.mp_M;
         cnt <= rand_lat ? int'($urandom_range(20, 1)) : fixed_lat;
      end else if (cnt != 0) begin
         if (bus.mp_A !== a_l || bus.mp_B !== b_l || bus.mp_M !== m_l) stab_err <= stab_err + 1;
         if (cnt == 1) begin
            model_done <= 1'b1;
            model_p    <= 8'(mont(int'(a_l), int'(b_l), int'(m_l)));
         end
         cnt <= cnt - 1;
      end
   end

   task automatic set_operands(input logic [7:0] e);
      bus.base_m = 8'd5;
      bus.one_m  = 8'd9;
      bus.M      = 8'd13;
      bus.exp    = e;
   endtask

   task automatic start_op(input logic [7:0] e, output int base_cnt);
      @(negedge clk);
      set_operands(e);
      bus.start = 1'b1;
      base_cnt  = n_starts;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_done(output int cyc, output int busy_low);
      cyc      = 0;
      busy_low = 0;
      while (bus.done !== 1'b1 && cyc < Limit) begin
         if (bus.busy !== 1'b1) busy_low++;
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic run_and_check(input string name, input logic [7:0] e, input int exp_res,
                                input int exp_pulses);
      int b0, cyc, bl, err0;
      err0 = stab_err;
      start_op(e, b0);
      wait_done(cyc, bl);
      checks++;
      if (cyc >= Limit) $display("FAIL %s_timeout: waited %0d cycles for done", name, cyc);
      else passes++;
      checks++;
      if (bus.result !== 8'(exp_res))
         $display("FAIL %s_result: got %0d, expected %0d", name, bus.result, exp_res);
      else passes++;
      checks++;
      if (n_starts - b0 !== exp_pulses)
         $display("FAIL %s_pulses: got %0d, expected %0d", name, n_starts - b0, exp_pulses);
      else passes++;
      checks++;
      if (bl !== 0) $display("FAIL %s_busy: busy low %0d cycles, expected 0", name, bl);
      else passes++;
      checks++;
      if (stab_err - err0 !== 0)
         $display("FAIL %s_stable: %0d operand errors, expected 0", name, stab_err - err0);
      else passes++;
      @(negedge clk);
      checks++;
      if ({bus.done, bus.busy} !== 2'b00)
         $display("FAIL %s_after: done/busy=%b, expected 00", name, {bus.done, bus.busy});
      else passes++;
   endtask

   task automatic test_reset;
      rst       = 1'b1;
      bus.start = 1'b0;
      set_operands(8'd0);
      repeat (3) @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b, expected 0", bus.busy);
      else passes++;
      checks++;
      if (bus.done !== 1'b0) $display("FAIL reset_done: got %b, expected 0", bus.done);
      else passes++;
      checks++;
      if (bus.result !== 8'd0) $display("FAIL reset_result: got %0d, expected 0", bus.result);
      else passes++;
      checks++;
      if (bus.mp_start !== 1'b0)
         $display("FAIL reset_mp_start: got %b, expected 0", bus.mp_start);
      else passes++;
      checks++;
      if ({bus.mp_A, bus.mp_B, bus.mp_M} !== 24'd0)
         $display("FAIL reset_mp_ops: got %h, expected 0", {bus.mp_A, bus.mp_B, bus.mp_M});
      else passes++;
      rst = 1'b0;
   endtask

   // 2^5 = 32 -> 6 ; 8 squares + 2 multiplies + 1 conversion
   task automatic test_basic;
      fixed_lat = 3;
      rand_lat  = 1'b0;
      run_and_check("basic", 8'd5, 6, 11);
   endtask

   // exp=0 -> 1 ; exp=255 -> 2^(255 mod 12) = 2^3 = 8
   task automatic test_exp_edges;
      run_and_check("exp_zero", 8'h00, 1, 9);
      run_and_check("exp_ones", 8'hFF, 8, 17);
   endtask

   // 0xA7 = 167 -> 2^11 = 2^-1 mod 13 = 7 ; popcount 5
   task automatic test_random_latency;
      rand_lat = 1'b1;
      run_and_check("rand_lat", 8'hA7, 7, 14);
      rand_lat = 1'b0;
   endtask

   task automatic test_mid_op_start;
      int b0, cyc, bl;
      rand_lat = 1'b1;
      start_op(8'd5, b0);
      repeat (6) @(negedge clk);
      bus.base_m = 8'd7;
      bus.one_m  = 8'd1;
      bus.exp    = 8'hFF;
      bus.M      = 8'd11;
      bus.start  = 1'b1;
      repeat (4) @(negedge clk);
      checks++;
      if (bus.mp_M !== 8'd13) $display("FAIL midop_mp_M: got %0d, expected 13", bus.mp_M);
      else passes++;
      bus.start = 1'b0;
      wait_done(cyc, bl);
      checks++;
      if (bus.result !== 8'd6 || cyc >= Limit)
         $display("FAIL midop_result: got %0d after %0d cycles, expected 6", bus.result, cyc);
      else passes++;
      checks++;
      if (n_starts - b0 !== 11)
         $display("FAIL midop_pulses: got %0d, expected 11", n_starts - b0);
      else passes++;
      set_operands(8'd0);
      rand_lat = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_op;
      int b0, b1;
      fixed_lat = 20;
      start_op(8'd5, b0);
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.mp_start} !== 2'b10)
         $display("FAIL rstmid_in_wait: busy/mp_start=%b, expected 10", {bus.busy, bus.mp_start});
      else passes++;
      rst = 1'b1;
      @(negedge clk);
      rst        = 1'b0;
      stray_p    = 8'h0C;
      stray_done = 1'b1;
      checks++;
      if ({bus.busy, bus.done, bus.mp_start} !== 3'b000 || bus.result !== 8'd0)
         $display("FAIL rstmid_flags: busy/done/mp_start=%b result=%0d, expected 000 and 0",
                  {bus.busy, bus.done, bus.mp_start}, bus.result);
      else passes++;
      checks++;
      if ({bus.mp_A, bus.mp_B, bus.mp_M} !== 24'd0)
         $display("FAIL rstmid_ops: got %h, expected 0", {bus.mp_A, bus.mp_B, bus.mp_M});
      else passes++;
      b1 = n_starts;
      @(negedge clk);
      stray_done = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if ({bus.busy, bus.done} !== 2'b00 || n_starts !== b1 || bus.result !== 8'd0)
         $display("FAIL rstmid_stray: busy/done=%b new starts=%0d result=%0d, expected 00 0 0",
                  {bus.busy, bus.done}, n_starts - b1, bus.result);
      else passes++;
      fixed_lat = 3;
      run_and_check("after_rst", 8'hA7, 7, 14);
   endtask

   task automatic test_back_to_back;
      int b0, b1, cyc, bl;
      start_op(8'd5, b0);
      wait_done(cyc, bl);
      checks++;
      if (bus.result !== 8'd6 || cyc >= Limit)
         $display("FAIL b2b_first: got %0d, expected 6", bus.result);
      else passes++;
      bus.exp   = 8'h00;
      bus.start = 1'b1;
      b1        = n_starts;
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.result !== 8'd6)
         $display("FAIL b2b_hold: busy=%b result=%0d, expected 0 and 6", bus.busy, bus.result);
      else passes++;
      @(negedge clk);
      bus.start = 1'b0;
      checks++;
      if (bus.busy !== 1'b1) $display("FAIL b2b_accept: busy=%b, expected 1", bus.busy);
      else passes++;
      wait_done(cyc, bl);
      checks++;
      if (bus.result !== 8'd1 || cyc >= Limit)
         $display("FAIL b2b_second: got %0d, expected 1", bus.result);
      else passes++;
      checks++;
      if (n_starts - b1 !== 9) $display("FAIL b2b_pulses: got %0d, expected 9", n_starts - b1);
      else passes++;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_exp_edges();
      test_random_latency();
      test_mid_op_start();
      test_reset_mid_op();
      test_back_to_back();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
